// File: rtl/fetch_decode_queue.sv
// Two-wide fetch-to-decode instruction queue with PC tagging,
// branch flush/redirect and drain reporting.
module fetch_decode_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             in_instr1,
  input  logic [31:0]             in_instr2,
  input  logic                    in_valid1,
  input  logic                    in_valid2,
  output logic                    in_ready,
  input  logic                    fetch_finish,
  input  logic                    flush,
  input  logic [31:0]             flush_pc,
  output logic [31:0]             out_instr1,
  output logic [31:0]             out_instr2,
  output logic [31:0]             out_pc1,
  output logic [31:0]             out_pc2,
  output logic                    out_valid1,
  output logic                    out_valid2,
  input  logic [1:0]              out_take,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr1;
  logic [AW-1:0] wr_ptr1;
  logic [31:0]   next_pc;
  logic          finish_latched;
  logic [1:0]    npush;
  logic [1:0]    npop;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  assign rd_ptr1 = rd_ptr + AW'(1);
  assign wr_ptr1 = wr_ptr + AW'(1);

  // Push/pop amounts; readiness only looks at registered occupancy
  always_comb begin
    in_ready = (count <= CW'(DEPTH - 2));
    npush    = 2'd0;
    if (in_ready && !finish_latched && !flush && in_valid1)
      npush = in_valid2 ? 2'd2 : 2'd1;
    npop = 2'd0;
    if (!flush) begin
      if (CW'(out_take) > count)
        npop = count[1:0];
      else
        npop = out_take;
    end
  end

  // Pointer, occupancy, PC tag and finish state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      next_pc        <= PC_RESET;
      finish_latched <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      next_pc <= flush_pc;
    end else begin
      wr_ptr  <= wr_ptr + AW'(npush);
      rd_ptr  <= rd_ptr + AW'(npop);
      count   <= count + CW'(npush) - CW'(npop);
      next_pc <= next_pc + {28'd0, npush, 2'b00};
      if (fetch_finish)
        finish_latched <= 1'b1;
    end
  end

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (npush != 2'd0) begin
      instr_mem[wr_ptr] <= in_instr1;
      pc_mem[wr_ptr]    <= next_pc;
    end
    if (npush == 2'd2) begin
      instr_mem[wr_ptr1] <= in_instr2;
      pc_mem[wr_ptr1]    <= next_pc + 32'd4;
    end
  end

  // First-word-fall-through view of the two oldest entries
  always_comb begin
    out_valid1 = (count != '0);
    out_valid2 = (count >= CW'(2));
    out_instr1 = out_valid1 ? instr_mem[rd_ptr]  : 32'd0;
    out_pc1    = out_valid1 ? pc_mem[rd_ptr]     : 32'd0;
    out_instr2 = out_valid2 ? instr_mem[rd_ptr1] : 32'd0;
    out_pc2    = out_valid2 ? pc_mem[rd_ptr1]    : 32'd0;
    drained    = finish_latched && (count == '0);
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: table vectors, hand sequences and
// a queue scoreboard checked every cycle.
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_instr1, in_instr2;
  logic        in_valid1, in_valid2;
  logic        in_ready;
  logic        fetch_finish;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] out_instr1, out_instr2, out_pc1, out_pc2;
  logic        out_valid1, out_valid2;
  logic [1:0]  out_take;
  logic [3:0]  count;
  logic        drained;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] m_pc;
  logic        m_fin;

  typedef struct {
    logic        v1;
    logic        v2;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  take;
    logic [3:0]  ecount;
    logic        eready;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  fetch_decode_queue #(.DEPTH(8), .PC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst),
    .in_instr1(in_instr1), .in_instr2(in_instr2),
    .in_valid1(in_valid1), .in_valid2(in_valid2),
    .in_ready(in_ready), .fetch_finish(fetch_finish),
    .flush(flush), .flush_pc(flush_pc),
    .out_instr1(out_instr1), .out_instr2(out_instr2),
    .out_pc1(out_pc1), .out_pc2(out_pc2),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_take(out_take), .count(count), .drained(drained)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc  = 32'h0;
    m_fin = 1'b0;
  endtask

  task automatic chk_model();
    int n;
    n = sb.size();
    chk("sb_valid1", 32'(out_valid1), 32'(n >= 1));
    chk("sb_valid2", 32'(out_valid2), 32'(n >= 2));
    chk("sb_instr1", out_instr1, n >= 1 ? sb[0].instr : 32'd0);
    chk("sb_pc1",    out_pc1,    n >= 1 ? sb[0].pc    : 32'd0);
    chk("sb_instr2", out_instr2, n >= 2 ? sb[1].instr : 32'd0);
    chk("sb_pc2",    out_pc2,    n >= 2 ? sb[1].pc    : 32'd0);
    chk("sb_count",  32'(count), 32'(n));
    chk("sb_ready",  32'(in_ready), 32'(n <= 6));
    chk("sb_drained", 32'(drained), 32'(m_fin && n == 0));
  endtask

  task automatic step(input logic v1, input logic v2,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] take, input logic fin,
                      input logic fl, input logic [31:0] fpc);
    int   n;
    int   np;
    logic acc;
    in_valid1    = v1;
    in_valid2    = v2;
    in_instr1    = a;
    in_instr2    = b;
    out_take     = take;
    fetch_finish = fin;
    flush        = fl;
    flush_pc     = fpc;
    @(negedge clk);
    chk_model();
    n = sb.size();
    if (fl) begin
      sb.delete();
      m_pc = fpc;
    end else begin
      acc = (n <= 6) && !m_fin && v1;
      np  = (int'(take) > n) ? n : int'(take);
      for (int i = 0; i < np; i++) void'(sb.pop_front());
      if (acc) begin
        sb.push_back('{a, m_pc});
        m_pc += 4;
        if (v2) begin
          sb.push_back('{b, m_pc});
          m_pc += 4;
        end
      end
      if (fin) m_fin = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    in_valid1    = 1'b0;
    in_valid2    = 1'b0;
    in_instr1    = '0;
    in_instr2    = '0;
    out_take     = '0;
    fetch_finish = 1'b0;
    flush        = 1'b0;
    flush_pc     = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tbl[0] = '{1, 1, 32'h11, 32'h12, 2'd0, 4'd2, 1'b1};
    tbl[1] = '{1, 1, 32'h21, 32'h22, 2'd0, 4'd4, 1'b1};
    tbl[2] = '{1, 1, 32'h31, 32'h32, 2'd0, 4'd6, 1'b1};
    tbl[3] = '{1, 1, 32'h41, 32'h42, 2'd0, 4'd8, 1'b0};
    tbl[4] = '{0, 0, 32'h0,  32'h0,  2'd1, 4'd7, 1'b0};
    tbl[5] = '{1, 1, 32'h51, 32'h52, 2'd0, 4'd7, 1'b0};
    tbl[6] = '{0, 0, 32'h0,  32'h0,  2'd1, 4'd6, 1'b1};
    tbl[7] = '{1, 1, 32'h61, 32'h62, 2'd0, 4'd8, 1'b0};
    tbl[8] = '{1, 1, 32'h71, 32'h72, 2'd2, 4'd6, 1'b1};

    rst          = 1'b1;
    in_valid1    = 1'b0;
    in_valid2    = 1'b0;
    in_instr1    = '0;
    in_instr2    = '0;
    out_take     = '0;
    fetch_finish = 1'b0;
    flush        = 1'b0;
    flush_pc     = '0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid1", 32'(out_valid1), 32'd0);
    chk("rst_drained", 32'(drained), 32'd0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v1, tbl[i].v2, tbl[i].a, tbl[i].b, tbl[i].take,
           1'b0, 1'b0, 32'd0);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].ecount));
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].eready));
      if (i == 2) begin
        chk("head_instr1", out_instr1, 32'h11);
        chk("head_pc1", out_pc1, 32'h0);
        chk("head_instr2", out_instr2, 32'h12);
        chk("head_pc2", out_pc2, 32'h4);
      end
    end
    chk("after_vec_pc1", out_pc1, 32'h10);

    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 32'h100 + 32'(2 * i), 32'h101 + 32'(2 * i),
           2'd2, 1'b0, 1'b0, 32'd0);
      chk("stream_count", 32'(count), 32'd6);
    end
    repeat (3) step(1'b0, 1'b0, 0, 0, 2'd2, 1'b0, 1'b0, 0);
    chk("drain_count", 32'(count), 32'd0);

    step(1'b1, 1'b0, 32'hAA, 32'h0, 2'd0, 1'b0, 1'b0, 0);
    chk("one_count", 32'(count), 32'd1);
    step(1'b0, 1'b0, 0, 0, 2'd2, 1'b0, 1'b0, 0);
    chk("clamp_count", 32'(count), 32'd0);
    chk("clamp_instr1", out_instr1, 32'd0);
    chk("clamp_pc1", out_pc1, 32'd0);
    step(1'b0, 1'b1, 0, 32'hBB, 2'd0, 1'b0, 1'b0, 0);
    chk("v2only_count", 32'(count), 32'd0);

    step(1'b1, 1'b1, 32'hC1, 32'hC2, 2'd0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 32'hC3, 32'hC4, 2'd0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 32'hC5, 32'h0,  2'd0, 1'b0, 1'b0, 0);
    chk("preflush_count", 32'(count), 32'd5);
    step(1'b1, 1'b1, 32'hD1, 32'hD2, 2'd2, 1'b0, 1'b1, 32'h100);
    chk("flush_count", 32'(count), 32'd0);
    step(1'b1, 1'b1, 32'hA1, 32'hA2, 2'd0, 1'b0, 1'b0, 0);
    chk("redir_pc1", out_pc1, 32'h100);
    chk("redir_pc2", out_pc2, 32'h104);
    chk("redir_instr1", out_instr1, 32'hA1);
    step(1'b0, 1'b0, 0, 0, 2'd2, 1'b0, 1'b0, 0);

    step(1'b1, 1'b1, 32'hE1, 32'hE2, 2'd0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 32'hE3, 32'hE4, 2'd0, 1'b1, 1'b0, 0);
    chk("fin_count", 32'(count), 32'd4);
    step(1'b1, 1'b1, 32'hE5, 32'hE6, 2'd0, 1'b0, 1'b0, 0);
    chk("fin_drop", 32'(count), 32'd4);
    chk("fin_notdrained", 32'(drained), 32'd0);
    step(1'b1, 1'b1, 32'hE7, 32'hE8, 2'd2, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 32'hE9, 32'hEA, 2'd2, 1'b0, 1'b0, 0);
    chk("fin_empty", 32'(count), 32'd0);
    chk("drained", 32'(drained), 32'd1);
    repeat (3) step(1'b1, 1'b1, 32'hF1, 32'hF2, 2'd1, 1'b0, 1'b0, 0);
    chk("drained_hold", 32'(drained), 32'd1);

    do_reset();
    chk("rst2_drained", 32'(drained), 32'd0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 32'h200 + 32'(i), 32'h300 + 32'(i),
           2'd0, 1'b0, 1'b0, 0);
    chk("pre_rst_count", 32'(count), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_ready", 32'(in_ready), 32'd1);
    chk("async_valid1", 32'(out_valid1), 32'd0);
    chk("async_instr1", out_instr1, 32'd0);
    chk("async_pc2", out_pc2, 32'd0);
    chk("async_drained", 32'(drained), 32'd0);
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle();
    chk("post_rst_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
